// File: rtl/code_ram_mp_pkg.sv
// Shared definitions for the multi-port code RAM: default widths, NOP word and load FSM states.
package code_ram_mp_pkg;

    localparam int PCWIDTH  = 4;
    localparam int INSWIDTH = 8;
    localparam logic [INSWIDTH-1:0] NOP = '0;

    typedef enum logic [1:0] {
        CR_EMPTY = 2'd0,
        CR_LOAD  = 2'd1,
        CR_RUN   = 2'd2
    } cr_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/code_ram_rdport.sv
// One fetch port: bounds check against the loaded code size and the registered response.
// With CODE_RAM_PARITY_EN defined, the stored parity bit is also checked.
module code_ram_rdport
    import code_ram_mp_pkg::*;
#(
    parameter int PCW  = PCWIDTH,
    parameter int INSW = INSWIDTH,
    parameter int CSW  = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            accept_i,
    input  logic [PCW-1:0]  pc_i,
    input  logic [CSW-1:0]  code_size_i,
    input  logic [INSW-1:0] word_i,
    output logic            valid_o,
    output logic [INSW-1:0] ins_o
`ifdef CODE_RAM_PARITY_EN
    ,
    input  logic            par_i,
    output logic            perr_o
`endif
);

    localparam int CMPW = max2(PCW, CSW);

    logic            in_range;
    logic            valid_q;
    logic [INSW-1:0] ins_q;

    assign in_range = CMPW'(pc_i) < CMPW'(code_size_i);

    // Without an accepted fetch the instruction register keeps its last value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            ins_q   <= '0;
        end else begin
            valid_q <= accept_i;
            if (accept_i)
                ins_q <= in_range ? word_i : '0;
        end
    end

    assign valid_o = valid_q;
    assign ins_o   = ins_q;

`ifdef CODE_RAM_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            perr_q <= 1'b0;
        else if (accept_i)
            perr_q <= in_range & ((^word_i) ^ par_i);
    end

    assign perr_o = perr_q;
`endif

endmodule

// File: rtl/code_ram_mp.sv
// Loadable multi-port instruction memory: load FSM, write pointer and storage; NPORT fetch ports.
// Define CODE_RAM_PARITY_EN to store an even-parity bit per word and report f_perr_o.
module code_ram_mp
    import code_ram_mp_pkg::*;
#(
    parameter int PCW   = PCWIDTH,
    parameter int INSW  = INSWIDTH,
    parameter int DEPTH = 8,
    parameter int NPORT = 2,
    parameter int CSW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [INSW-1:0]       load_data_i,
    input  logic                  load_last_i,
    output logic                  loading_o,
    output logic                  load_ovf_o,
    output logic [CSW-1:0]        code_size_o,
    input  logic [NPORT-1:0]      f_req_i,
    input  logic [NPORT*PCW-1:0]  f_pc_i,
    output logic [NPORT-1:0]      f_ready_o,
    output logic [NPORT-1:0]      f_valid_o,
    output logic [NPORT*INSW-1:0] f_ins_o
`ifdef CODE_RAM_PARITY_EN
    ,
    output logic [NPORT-1:0]      f_perr_o
`endif
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMPW = max2(PCW, CSW);

    cr_state_e       state_q;
    logic [CSW-1:0]  wptr_q;
    logic [CSW-1:0]  code_size_q;
    logic [CSW-1:0]  code_size_d;
    logic            load_ovf_q;
    logic            loading_q;
    logic            wptr_full;
    logic            wr_en;

    logic [INSW-1:0] codes_q [DEPTH];

    assign wptr_full   = wptr_q >= CSW'(DEPTH);
    assign code_size_d = wptr_full ? CSW'(DEPTH) : wptr_q + CSW'(1);
    // A load_valid coinciding with load_start belongs to no program and is dropped.
    assign wr_en       = (state_q == CR_LOAD) && load_valid_i && !load_start_i && !wptr_full;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= CR_EMPTY;
            wptr_q      <= '0;
            code_size_q <= '0;
            load_ovf_q  <= 1'b0;
            loading_q   <= 1'b0;
        end else if (load_start_i) begin
            state_q     <= CR_LOAD;
            wptr_q      <= '0;
            code_size_q <= '0;
            load_ovf_q  <= 1'b0;
            loading_q   <= 1'b1;
        end else if (state_q == CR_LOAD && load_valid_i) begin
            // The pointer saturates at DEPTH so long loads cannot wrap back into range.
            if (wptr_full)
                load_ovf_q <= 1'b1;
            else
                wptr_q <= wptr_q + CSW'(1);
            if (load_last_i) begin
                state_q     <= CR_RUN;
                code_size_q <= code_size_d;
                loading_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            codes_q[wptr_q[AW-1:0]] <= load_data_i;
    end

`ifdef CODE_RAM_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en)
            par_q[wptr_q[AW-1:0]] <= ^load_data_i;
    end
`endif

    assign loading_o   = loading_q;
    assign load_ovf_o  = load_ovf_q;
    assign code_size_o = code_size_q;
    assign f_ready_o   = {NPORT{state_q != CR_LOAD}};

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        logic [PCW-1:0]  pc;
        logic            in_mem;
        logic [INSW-1:0] word;

        assign pc     = f_pc_i[g*PCW +: PCW];
        assign in_mem = CMPW'(pc) < CMPW'(DEPTH);
        assign word   = in_mem ? codes_q[pc[AW-1:0]] : NOP;

`ifdef CODE_RAM_PARITY_EN
        logic par;
        assign par = in_mem ? par_q[pc[AW-1:0]] : 1'b0;
`endif

        code_ram_rdport #(
            .PCW  (PCW),
            .INSW (INSW),
            .CSW  (CSW)
        ) u_rdport (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .accept_i    (f_req_i[g] & f_ready_o[g]),
            .pc_i        (pc),
            .code_size_i (code_size_q),
            .word_i      (word),
            .valid_o     (f_valid_o[g]),
            .ins_o       (f_ins_o[g*INSW +: INSW])
`ifdef CODE_RAM_PARITY_EN
            ,
            .par_i       (par),
            .perr_o      (f_perr_o[g])
`endif
        );
    end

endmodule

// File: tb/tb_code_ram_mp.sv
// Directed bench for code_ram_mp with default parameters (PCW=4, INSW=8, DEPTH=8, NPORT=2).
module tb_code_ram_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, load_valid, load_last;
    logic [7:0]  load_data;
    logic        loading, load_ovf;
    logic [3:0]  code_size;
    logic [1:0]  f_req, f_ready, f_valid;
    logic [7:0]  f_pc;
    logic [15:0] f_ins;
`ifdef CODE_RAM_PARITY_EN
    logic [1:0]  f_perr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    code_ram_mp dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .load_start_i (load_start),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_last_i  (load_last),
        .loading_o    (loading),
        .load_ovf_o   (load_ovf),
        .code_size_o  (code_size),
        .f_req_i      (f_req),
        .f_pc_i       (f_pc),
        .f_ready_o    (f_ready),
        .f_valid_o    (f_valid),
        .f_ins_o      (f_ins)
`ifdef CODE_RAM_PARITY_EN
        ,
        .f_perr_o     (f_perr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
        f_req = 0; f_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_code_size", 32'(code_size), 0);
        check("rst_valid", 32'(f_valid), 0);
        check("rst_ins", 32'(f_ins), 0);
        check("rst_loading", 32'(loading), 0);
        check("rst_ovf", 32'(load_ovf), 0);
        check("rst_ready", 32'(f_ready), 32'h3);
        rst_n = 1'b1;
        tick();

        // EMPTY: fetches complete but return NOP
        f_req = 2'b11; f_pc = 8'h00;
        tick();
        check("empty_valid", 32'(f_valid), 32'h3);
        check("empty_ins", 32'(f_ins), 0);
        f_req = 2'b00;
        tick();
        check("idle_valid", 32'(f_valid), 0);

        // 3-word program
        load_start = 1; tick(); load_start = 0;
        check("load_loading", 32'(loading), 1);
        check("load_ready", 32'(f_ready), 0);
        push(8'hA1, 0); push(8'hB2, 0); push(8'hC3, 1);
        check("p3_loading", 32'(loading), 0);
        check("p3_size", 32'(code_size), 3);
        check("p3_ovf", 32'(load_ovf), 0);
        f_req = 2'b11; f_pc = {4'd2, 4'd1};
        tick();
        check("p3_fetch12", 32'(f_ins), 32'hC3B2);
        check("p3_valid", 32'(f_valid), 32'h3);
        f_pc = {4'd0, 4'd3};
        tick();
        check("p3_fetch03", 32'(f_ins), 32'hA100);
        f_req = 2'b00;
        tick();
        check("p3_hold_valid", 32'(f_valid), 0);
        check("p3_hold_ins", 32'(f_ins), 32'hA100);

        // fetch in the same cycle as load_start sees the old program
        f_req = 2'b01; f_pc = {4'd0, 4'd2}; load_start = 1;
        tick();
        load_start = 0;
        check("race_valid", 32'(f_valid), 32'h1);
        check("race_ins", 32'(f_ins), 32'hA1C3);
        check("race_loading", 32'(loading), 1);
        f_req = 2'b11;
        tick();
        check("inload_valid", 32'(f_valid), 0);
        check("inload_ready", 32'(f_ready), 0);
        check("inload_ins", 32'(f_ins), 32'hA1C3);
        f_req = 2'b00;

        // 10 words into DEPTH=8
        for (int i = 0; i < 10; i++) push(8'(8'h10 + i), i == 9);
        check("ovf_flag", 32'(load_ovf), 1);
        check("ovf_size", 32'(code_size), 8);
        check("ovf_loading", 32'(loading), 0);
        f_req = 2'b11; f_pc = {4'd8, 4'd7};
        tick();
        check("ovf_fetch78", 32'(f_ins), 32'h0017);
        f_pc = {4'd15, 4'd0};
        tick();
        check("ovf_fetch0f", 32'(f_ins), 32'h0010);
        f_req = 2'b00;
        tick();

        // reset in the middle of a load
        load_start = 1; tick(); load_start = 0;
        push(8'h21, 0); push(8'h22, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_size", 32'(code_size), 0);
        check("midrst_valid", 32'(f_valid), 0);
        check("midrst_loading", 32'(loading), 0);
        check("midrst_ovf", 32'(load_ovf), 0);
        #2;
        rst_n = 1'b1;
        tick();
        f_req = 2'b11; f_pc = 8'h00;
        tick();
        check("midrst_fetch_valid", 32'(f_valid), 32'h3);
        check("midrst_fetch_ins", 32'(f_ins), 0);
        f_req = 2'b00;

        // load_valid with load_start is ignored; load_last alone is ignored
        load_start = 1; load_valid = 1; load_data = 8'h99;
        tick();
        load_start = 0; load_valid = 0;
        push(8'h55, 0);
        load_last = 1;
        tick();
        load_last = 0;
        check("lastonly_loading", 32'(loading), 1);
        push(8'h66, 1);
        check("p2_size", 32'(code_size), 2);
        f_req = 2'b11; f_pc = {4'd0, 4'd1};
        tick();
        check("p2_fetch10", 32'(f_ins), 32'h5566);
        f_pc = {4'd2, 4'd2};
        tick();
        check("p2_fetch_oob", 32'(f_ins), 0);

`ifdef CODE_RAM_PARITY_EN
        dut.codes_q[1] = dut.codes_q[1] ^ 8'h01;
        f_pc = {4'd0, 4'd1};
        tick();
        check("perr_flip", 32'(f_perr), 32'h1);
        f_pc = {4'd0, 4'd0};
        tick();
        check("perr_clean", 32'(f_perr), 0);
`endif

        f_req = 2'b00;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
